// File: rtl/ervp_orca_cache_oimm_arbiter_pkg.sv
// Shared types for the ORCA cache OIMM two-port arbiter.
// Holds the FSM encoding and the return-route entry layout.
package ervp_orca_cache_oimm_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_WBURST  = 2'd2
    } arb_state_e;

    localparam int unsigned BW_PORT_ID = 1;

    // Route entry is {port_id, burstlength_minus1}.
    function automatic int unsigned route_width(input int unsigned bw_burst_length);
        return BW_PORT_ID + bw_burst_length;
    endfunction

endpackage

// File: rtl/ervp_orca_cache_oimm_arbiter_route_fifo.sv
// In-order return-route FIFO with synchronous active-high reset.
// Push and pop may coincide, including on a full FIFO.
module ervp_orca_cache_oimm_arbiter_route_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned BW_PTR = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [BW_PTR:0]  wr_ptr_q;
    logic [BW_PTR:0]  rd_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (BW_PTR+1)'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + (BW_PTR+1)'(1);
        end
    end

    // Storage needs no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[BW_PTR-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q[BW_PTR-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[BW_PTR] != rd_ptr_q[BW_PTR]) &&
                     (wr_ptr_q[BW_PTR-1:0] == rd_ptr_q[BW_PTR-1:0]);

endmodule

// File: rtl/ervp_orca_cache_oimm_arbiter.sv
// Round-robin arbiter sharing one OIMM master between the I-cache (s0) and D-cache (s1).
// Commands pass through with zero latency; read beats are routed back via an in-order FIFO.
module ervp_orca_cache_oimm_arbiter
    import ervp_orca_cache_oimm_arbiter_pkg::*;
#(
    parameter int unsigned BW_ADDR              = 32,
    parameter int unsigned BW_DATA              = 32,
    parameter int unsigned BW_BURST_LENGTH      = 4,
    parameter int unsigned MAX_OUTSTANDING_READ = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [BW_ADDR-1:0]         s0_oimm_address,
    input  logic [BW_BURST_LENGTH-1:0] s0_oimm_burstlength_minus1,
    input  logic [BW_DATA/8-1:0]       s0_oimm_byteenable,
    input  logic                       s0_oimm_requestvalid,
    input  logic                       s0_oimm_readnotwrite,
    input  logic [BW_DATA-1:0]         s0_oimm_writedata,
    input  logic                       s0_oimm_writelast,
    output logic [BW_DATA-1:0]         s0_oimm_readdata,
    output logic                       s0_oimm_readdatavalid,
    output logic                       s0_oimm_waitrequest,

    input  logic [BW_ADDR-1:0]         s1_oimm_address,
    input  logic [BW_BURST_LENGTH-1:0] s1_oimm_burstlength_minus1,
    input  logic [BW_DATA/8-1:0]       s1_oimm_byteenable,
    input  logic                       s1_oimm_requestvalid,
    input  logic                       s1_oimm_readnotwrite,
    input  logic [BW_DATA-1:0]         s1_oimm_writedata,
    input  logic                       s1_oimm_writelast,
    output logic [BW_DATA-1:0]         s1_oimm_readdata,
    output logic                       s1_oimm_readdatavalid,
    output logic                       s1_oimm_waitrequest,

    output logic [BW_ADDR-1:0]         m_oimm_address,
    output logic [BW_BURST_LENGTH-1:0] m_oimm_burstlength_minus1,
    output logic [BW_DATA/8-1:0]       m_oimm_byteenable,
    output logic                       m_oimm_requestvalid,
    output logic                       m_oimm_readnotwrite,
    output logic [BW_DATA-1:0]         m_oimm_writedata,
    output logic                       m_oimm_writelast,
    input  logic [BW_DATA-1:0]         m_oimm_readdata,
    input  logic                       m_oimm_readdatavalid,
    input  logic                       m_oimm_waitrequest,

    input  logic                       m_busy,
    output logic                       busy,
    output logic                       err_unexpected_rdata
);
    localparam int unsigned BW_ROUTE = route_width(BW_BURST_LENGTH);

    arb_state_e                 state_q, state_d;
    logic                       grant_q, grant_d;
    logic                       rr_q, rr_d;
    logic [BW_BURST_LENGTH-1:0] beat_cnt_q, beat_cnt_d;
    logic                       err_q, err_d;

    logic                       sel;
    logic                       win_rv;
    logic                       win_rnw;
    logic                       win_wlast;
    logic [BW_BURST_LENGTH-1:0] win_bl;
    logic                       read_blocked;
    logic                       accept;

    logic                       route_push;
    logic                       route_pop;
    logic                       route_hit;
    logic [BW_ROUTE-1:0]        route_wdata;
    logic [BW_ROUTE-1:0]        route_head;
    logic                       route_empty;
    logic                       route_full;
    logic                       head_port;
    logic [BW_BURST_LENGTH-1:0] head_len;

    // In IDLE the grant is live; otherwise it is held on the latched port.
    always_comb begin
        sel = grant_q;
        if (state_q == ST_IDLE) begin
            sel = (s0_oimm_requestvalid && s1_oimm_requestvalid) ? rr_q : s1_oimm_requestvalid;
        end
    end

    assign win_rv    = sel ? s1_oimm_requestvalid       : s0_oimm_requestvalid;
    assign win_rnw   = sel ? s1_oimm_readnotwrite       : s0_oimm_readnotwrite;
    assign win_wlast = sel ? s1_oimm_writelast          : s0_oimm_writelast;
    assign win_bl    = sel ? s1_oimm_burstlength_minus1 : s0_oimm_burstlength_minus1;

    assign m_oimm_address            = sel ? s1_oimm_address    : s0_oimm_address;
    assign m_oimm_byteenable         = sel ? s1_oimm_byteenable : s0_oimm_byteenable;
    assign m_oimm_writedata          = sel ? s1_oimm_writedata  : s0_oimm_writedata;
    assign m_oimm_burstlength_minus1 = win_bl;
    assign m_oimm_readnotwrite       = win_rnw;
    assign m_oimm_writelast          = win_wlast;

    // A pop in this cycle frees a slot, so a full FIFO can still take a read.
    assign read_blocked        = win_rnw && route_full && !route_pop;
    assign m_oimm_requestvalid = win_rv && !read_blocked;
    assign accept              = m_oimm_requestvalid && !m_oimm_waitrequest;

    assign s0_oimm_waitrequest = sel  ? 1'b1 : (m_oimm_waitrequest || read_blocked);
    assign s1_oimm_waitrequest = !sel ? 1'b1 : (m_oimm_waitrequest || read_blocked);

    assign route_push  = accept && win_rnw;
    assign route_wdata = {sel, win_bl};

    ervp_orca_cache_oimm_arbiter_route_fifo #(
        .DEPTH (MAX_OUTSTANDING_READ),
        .WIDTH (BW_ROUTE)
    ) u_route_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (route_push),
        .wdata_i (route_wdata),
        .pop_i   (route_pop),
        .rdata_o (route_head),
        .empty_o (route_empty),
        .full_o  (route_full)
    );

    assign head_port = route_head[BW_ROUTE-1];
    assign head_len  = route_head[BW_BURST_LENGTH-1:0];
    assign route_hit = m_oimm_readdatavalid && !route_empty;
    assign route_pop = route_hit && (beat_cnt_q == head_len);

    assign s0_oimm_readdata      = m_oimm_readdata;
    assign s1_oimm_readdata      = m_oimm_readdata;
    assign s0_oimm_readdatavalid = route_hit && !head_port;
    assign s1_oimm_readdatavalid = route_hit && head_port;

    assign busy                 = (state_q != ST_IDLE) || !route_empty || m_busy;
    assign err_unexpected_rdata = err_q;

    // Command FSM: whole commands arbitrated, write bursts locked until writelast.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE, ST_PENDING: begin
                if (m_oimm_requestvalid) begin
                    grant_d = sel;
                    if (m_oimm_waitrequest) begin
                        state_d = ST_PENDING;
                    end else if (win_rnw) begin
                        state_d = ST_IDLE;
                        rr_d    = !sel;
                    end else if (win_wlast) begin
                        state_d = ST_IDLE;
                        rr_d    = !rr_q;
                    end else begin
                        state_d = ST_WBURST;
                    end
                end
            end
            ST_WBURST: begin
                if (accept && win_wlast) begin
                    state_d = ST_IDLE;
                    rr_d    = !rr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (route_hit) begin
            beat_cnt_d = route_pop ? '0 : beat_cnt_q + BW_BURST_LENGTH'(1);
        end
        err_d = err_q || (m_oimm_readdatavalid && route_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            rr_q       <= 1'b0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_ervp_orca_cache_oimm_arbiter.sv
// Self-checking bench for ervp_orca_cache_oimm_arbiter: directed scenarios then random traffic,
// checked every cycle against a requester/ownership/outstanding-read model.
module tb_ervp_orca_cache_oimm_arbiter;
    localparam int unsigned MAX_OR = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] s_addr [2];
    logic [3:0]  s_bl   [2];
    logic [3:0]  s_be   [2];
    logic        s_rv   [2];
    logic        s_rnw  [2];
    logic [31:0] s_wd   [2];
    logic        s_wl   [2];
    logic [31:0] s_rd   [2];
    logic        s_rdv  [2];
    logic        s_wait [2];

    logic [31:0] m_addr, m_wd, m_rd;
    logic [3:0]  m_bl, m_be;
    logic        m_rv, m_rnw, m_wl, m_rdv, m_wait, m_busy, busy, err;

    ervp_orca_cache_oimm_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_oimm_address(s_addr[0]), .s0_oimm_burstlength_minus1(s_bl[0]),
        .s0_oimm_byteenable(s_be[0]), .s0_oimm_requestvalid(s_rv[0]),
        .s0_oimm_readnotwrite(s_rnw[0]), .s0_oimm_writedata(s_wd[0]),
        .s0_oimm_writelast(s_wl[0]), .s0_oimm_readdata(s_rd[0]),
        .s0_oimm_readdatavalid(s_rdv[0]), .s0_oimm_waitrequest(s_wait[0]),
        .s1_oimm_address(s_addr[1]), .s1_oimm_burstlength_minus1(s_bl[1]),
        .s1_oimm_byteenable(s_be[1]), .s1_oimm_requestvalid(s_rv[1]),
        .s1_oimm_readnotwrite(s_rnw[1]), .s1_oimm_writedata(s_wd[1]),
        .s1_oimm_writelast(s_wl[1]), .s1_oimm_readdata(s_rd[1]),
        .s1_oimm_readdatavalid(s_rdv[1]), .s1_oimm_waitrequest(s_wait[1]),
        .m_oimm_address(m_addr), .m_oimm_burstlength_minus1(m_bl),
        .m_oimm_byteenable(m_be), .m_oimm_requestvalid(m_rv),
        .m_oimm_readnotwrite(m_rnw), .m_oimm_writedata(m_wd),
        .m_oimm_writelast(m_wl), .m_oimm_readdata(m_rd),
        .m_oimm_readdatavalid(m_rdv), .m_oimm_waitrequest(m_wait),
        .m_busy(m_busy), .busy(busy), .err_unexpected_rdata(err)
    );

    typedef struct {
        bit          rnw;
        logic [31:0] addr;
        int          len;
        int          start;
        logic [3:0]  be;
    } cmd_t;

    typedef struct {
        int port;
        int left;
    } rcmd_t;

    cmd_t  cq0[$];
    cmd_t  cq1[$];
    int    bidx [2];
    rcmd_t outq[$];
    int    obs_rdv[$];

    // Model: who owns the master (0 free, 1 waiting on accept, 2 write burst), round-robin pointer.
    int lock, lock_port, ds_beats, cyc;
    bit rr, err_m;
    bit force_wait, ret_en, inject, one_ret, rand_busy, busy_force;
    int wait_pct, ret_pct;
    int n_assert, n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int p);
        return (p == 0) ? cq0.size() : cq1.size();
    endfunction

    function automatic cmd_t head_cmd(input int p);
        return (p == 0) ? cq0[0] : cq1[0];
    endfunction

    task automatic add_cmd(input int p, input bit rnw, input logic [31:0] addr, input int len, input int start);
        cmd_t c;
        c.rnw = rnw; c.addr = addr; c.len = len; c.start = start; c.be = 4'($urandom_range(15));
        if (p == 0) cq0.push_back(c); else cq1.push_back(c);
    endtask

    task automatic pop_cmd(input int p);
        if (p == 0) void'(cq0.pop_front()); else void'(cq1.pop_front());
        bidx[p] = 0;
    endtask

    task automatic drive_inputs();
        cmd_t c;
        for (int p = 0; p < 2; p++) begin
            s_rv[p] = 1'b0; s_rnw[p] = 1'b0; s_wl[p] = 1'b0;
            s_addr[p] = '0; s_bl[p] = '0; s_be[p] = '0; s_wd[p] = '0;
            if (qsize(p) > 0) begin
                c = head_cmd(p);
                if (cyc >= c.start) begin
                    s_rv[p]   = 1'b1;
                    s_rnw[p]  = c.rnw;
                    s_addr[p] = c.addr;
                    s_bl[p]   = 4'(c.len);
                    s_be[p]   = c.be;
                    s_wd[p]   = {c.addr[15:0], 12'h0, 4'(bidx[p])};
                    s_wl[p]   = !c.rnw && (bidx[p] == c.len);
                end
            end
        end
        m_wait = force_wait ? 1'b1 : ($urandom_range(99) < 32'(wait_pct));
        m_rdv  = 1'b0;
        if (inject || one_ret) m_rdv = 1'b1;
        else if (ret_en && ds_beats > 0 && $urandom_range(99) < 32'(ret_pct)) m_rdv = 1'b1;
        if (rst) m_rdv = 1'b0;
        inject  = 1'b0;
        one_ret = 1'b0;
        m_rd    = $urandom();
        m_busy  = rand_busy ? 1'($urandom_range(1)) : busy_force;
    endtask

    task automatic check_and_update();
        int  w;
        bit  pop_now, full_eff, blk, mrv, acc, exp_rdv;
        pop_now  = m_rdv && outq.size() > 0 && outq[0].left == 1;
        full_eff = (outq.size() == MAX_OR) && !pop_now;
        if (lock != 0)              w = lock_port;
        else if (s_rv[0] && s_rv[1]) w = int'(rr);
        else if (s_rv[1])           w = 1;
        else                        w = 0;
        blk = s_rnw[w] && full_eff;
        mrv = s_rv[w] && !blk;
        acc = mrv && !m_wait;

        chk("m_requestvalid", 64'(m_rv), 64'(mrv));
        if (mrv) begin
            chk("m_address", 64'(m_addr), 64'(s_addr[w]));
            chk("m_readnotwrite", 64'(m_rnw), 64'(s_rnw[w]));
            chk("m_burstlength", 64'(m_bl), 64'(s_bl[w]));
            chk("m_byteenable", 64'(m_be), 64'(s_be[w]));
            if (!s_rnw[w]) begin
                chk("m_writedata", 64'(m_wd), 64'(s_wd[w]));
                chk("m_writelast", 64'(m_wl), 64'(s_wl[w]));
            end
        end
        chk("granted_waitrequest", 64'(s_wait[w]), 64'(m_wait || blk));
        chk("other_waitrequest", 64'(s_wait[1-w]), 64'(1));
        for (int p = 0; p < 2; p++) begin
            exp_rdv = m_rdv && outq.size() > 0 && outq[0].port == p;
            chk(p == 0 ? "s0_readdatavalid" : "s1_readdatavalid", 64'(s_rdv[p]), 64'(exp_rdv));
            if (s_rdv[p]) obs_rdv.push_back(p);
        end
        if (m_rdv) chk("readdata_broadcast", {s_rd[1], s_rd[0]}, {m_rd, m_rd});
        chk("busy", 64'(busy), 64'(lock != 0 || outq.size() > 0 || m_busy));
        chk("err_unexpected_rdata", 64'(err), 64'(err_m));

        // Return path: oldest outstanding read owns every beat until it is complete.
        if (m_rdv) begin
            if (outq.size() == 0) err_m = 1'b1;
            else begin
                outq[0].left--;
                if (outq[0].left == 0) void'(outq.pop_front());
            end
            if (ds_beats > 0) ds_beats--;
        end
        if (mrv) begin
            if (lock == 2) begin
                if (acc && s_wl[w]) begin lock = 0; rr = !rr; end
            end else if (m_wait) begin
                lock = 1; lock_port = w;
            end else if (s_rnw[w]) begin
                outq.push_back('{w, int'(s_bl[w]) + 1});
                ds_beats += int'(s_bl[w]) + 1;
                rr = (w == 0);
                lock = 0;
            end else if (s_wl[w]) begin
                lock = 0; rr = !rr;
            end else begin
                lock = 2; lock_port = w;
            end
        end
        if (acc) begin
            if (s_rnw[w] || s_wl[w]) pop_cmd(w);
            else bidx[w]++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst) check_and_update();
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cq0.delete(); cq1.delete();
        bidx[0] = 0; bidx[1] = 0;
        drive_inputs();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        lock = 0; lock_port = 0; rr = 1'b0; err_m = 1'b0;
        outq.delete();
        drive_inputs();
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((cq0.size() + cq1.size() + outq.size() + ds_beats) != 0 || lock != 0) begin
            if (n >= budget) break;
            step();
            n++;
        end
        chk(tag, 64'(cq0.size() + cq1.size() + outq.size() + ds_beats + lock), 64'(0));
        step();
    endtask

    initial begin
        logic [7:0] order;
        n_assert = 0; n_fail = 0; cyc = 0;
        lock = 0; lock_port = 0; rr = 1'b0; err_m = 1'b0; ds_beats = 0;
        force_wait = 0; ret_en = 0; inject = 0; one_ret = 0;
        rand_busy = 0; busy_force = 0; wait_pct = 0; ret_pct = 100;
        bidx[0] = 0; bidx[1] = 0;
        rst = 1'b1;
        drive_inputs();
        @(posedge clk); #1;
        do_reset();

        // Idle after reset, busy follows m_busy.
        busy_force = 1'b1; step(); step();
        busy_force = 1'b0; step();

        // Simultaneous reads: s0 first, then s1; returns routed in issue order.
        obs_rdv.delete();
        add_cmd(0, 1'b1, 32'h0000_1000, 3, cyc + 1);
        add_cmd(1, 1'b1, 32'h0000_2000, 3, cyc + 1);
        repeat (4) step();
        ret_en = 1'b1;
        drain("t1_drain", 100);
        order = '0;
        for (int i = 0; i < obs_rdv.size() && i < 8; i++) order[i] = obs_rdv[i][0];
        chk("t1_return_count", 64'(obs_rdv.size()), 64'(8));
        chk("t1_return_order", 64'(order), 64'(8'hF0));

        // s1 write burst locks the master; s0 read arrives mid-burst.
        add_cmd(1, 1'b0, 32'h0000_3000, 3, cyc + 1);
        add_cmd(0, 1'b1, 32'h0000_4000, 0, cyc + 3);
        drain("t2_drain", 100);

        // Downstream stall on an s0 read while s1 also requests.
        force_wait = 1'b1;
        add_cmd(0, 1'b1, 32'h0000_5000, 1, cyc + 1);
        add_cmd(1, 1'b0, 32'h0000_6000, 0, cyc + 1);
        repeat (3) step();
        force_wait = 1'b0;
        drain("t3_drain", 100);

        // Route FIFO full: fifth read stalls until a pop frees a slot.
        ret_en = 1'b0;
        for (int i = 0; i < 5; i++) add_cmd(0, 1'b1, 32'h0000_7000 + 32'(i * 4), 0, cyc + 1);
        repeat (8) step();
        one_ret = 1'b1;
        repeat (3) step();
        ret_en = 1'b1;
        drain("t4_drain", 100);

        // Read beat with nothing outstanding sets the sticky error.
        inject = 1'b1;
        repeat (5) step();
        chk("t5_err_sticky", 64'(err), 64'(1));

        // Reset in the middle of a write burst with two reads outstanding.
        ret_en = 1'b0;
        add_cmd(0, 1'b1, 32'h0000_8000, 1, cyc + 1);
        add_cmd(0, 1'b1, 32'h0000_8040, 1, cyc + 1);
        add_cmd(1, 1'b0, 32'h0000_9000, 3, cyc + 4);
        for (int i = 0; i < 30; i++) begin
            if (lock == 2 && bidx[1] == 2) break;
            step();
        end
        chk("t6_reached_burst", 64'(lock == 2 && bidx[1] == 2), 64'(1));
        do_reset();
        busy_force = 1'b1; step();
        busy_force = 1'b0; step();
        ret_en = 1'b1;
        drain("t6_drain", 100);
        chk("t6_late_beats_unexpected", 64'(err), 64'(1));
        do_reset();

        // Random mixed traffic with random stalls, returns and m_busy.
        rand_busy = 1'b1; wait_pct = 25; ret_pct = 60;
        for (int i = 0; i < 1500; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (qsize(p) < 2 && $urandom_range(3) == 0)
                    add_cmd(p, 1'($urandom_range(1)), {16'h0, 16'($urandom_range(16'hFFFF))} & 32'hFFFF_FFFC,
                            int'($urandom_range(3)), cyc + 1 + int'($urandom_range(2)));
            end
            step();
        end
        rand_busy = 1'b0; wait_pct = 0; ret_pct = 100;
        drain("random_drain", 400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
